// File: rtl/sdes_pkg.sv
// Shared types, permutations and S-box tables for the S-DES core.
// Bit numbering: vector MSB corresponds to S-DES bit 1.
package sdes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEYGEN,
    ST_RND1,
    ST_RND2,
    ST_DONE
  } sdes_state_t;

  // Indexed by {row, col}, row = bits 1,4 and col = bits 2,3 of the nibble.
  localparam logic [1:0] S0_LUT [16] = '{
    2'd1, 2'd0, 2'd3, 2'd2,
    2'd3, 2'd2, 2'd1, 2'd0,
    2'd0, 2'd2, 2'd1, 2'd3,
    2'd3, 2'd1, 2'd3, 2'd2
  };

  localparam logic [1:0] S1_LUT [16] = '{
    2'd0, 2'd1, 2'd2, 2'd3,
    2'd2, 2'd0, 2'd1, 2'd3,
    2'd3, 2'd0, 2'd1, 2'd0,
    2'd2, 2'd1, 2'd0, 2'd3
  };

  function automatic logic [9:0] p10(input logic [9:0] k);
    return {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
  endfunction

  function automatic logic [7:0] p8(input logic [9:0] k);
    return {k[4], k[7], k[3], k[6], k[2], k[5], k[0], k[1]};
  endfunction

  function automatic logic [4:0] ls(input logic [4:0] h, input logic [2:0] n);
    return (h << n) | (h >> (3'd5 - n));
  endfunction

  function automatic logic [7:0] ip(input logic [7:0] d);
    return {d[6], d[2], d[5], d[7], d[4], d[0], d[3], d[1]};
  endfunction

  function automatic logic [7:0] ip_inv(input logic [7:0] d);
    return {d[4], d[7], d[5], d[3], d[1], d[6], d[0], d[2]};
  endfunction

  function automatic logic [7:0] ep(input logic [3:0] r);
    return {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]};
  endfunction

  function automatic logic [3:0] p4(input logic [3:0] s);
    return {s[2], s[0], s[1], s[3]};
  endfunction

  function automatic logic [3:0] sbox_addr(input logic [3:0] n);
    return {n[3], n[0], n[2], n[1]};
  endfunction

endpackage

// File: rtl/sdes_fk.sv
// Combinational S-DES round function fk: L' = L xor F(R, SK), R passes through.
module sdes_fk
  import sdes_pkg::*;
(
  input  logic [3:0] l,
  input  logic [3:0] r,
  input  logic [7:0] sk,
  output logic [3:0] l_out,
  output logic [3:0] r_out
);

  logic [7:0] mixed;
  logic [1:0] s0_val;
  logic [1:0] s1_val;

  assign mixed  = ep(r) ^ sk;
  assign s0_val = S0_LUT[sbox_addr(mixed[7:4])];
  assign s1_val = S1_LUT[sbox_addr(mixed[3:0])];
  assign l_out  = l ^ p4({s0_val, s1_val});
  assign r_out  = r;

endmodule

// File: rtl/sdes_decrypt_core.sv
// Iterative S-DES engine, one stage per clock, valid/ready on both sides.
// ENCRYPT swaps the subkey order so the same core can run the forward cipher.
module sdes_decrypt_core
  import sdes_pkg::*;
#(
  parameter bit ENCRYPT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] ciphertext,
  input  logic [9:0] key,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] plaintext,
  output logic       busy
);

  sdes_state_t state_reg, state_next;

  logic [9:0] key_reg;
  logic [7:0] k1_reg, k2_reg;
  logic [7:0] data_reg;
  logic [7:0] plaintext_reg;

  logic [9:0] p10_key;
  logic [4:0] ls1_l, ls1_r;
  logic [7:0] k1_next, k2_next;
  logic [7:0] round_sk;
  logic [3:0] fk_l, fk_r;

  // Subkey schedule computed from the latched key only.
  assign p10_key = p10(key_reg);
  assign ls1_l   = ls(p10_key[9:5], 3'd1);
  assign ls1_r   = ls(p10_key[4:0], 3'd1);
  assign k1_next = p8({ls1_l, ls1_r});
  assign k2_next = p8({ls(ls1_l, 3'd2), ls(ls1_r, 3'd2)});

  // One fk instance shared by both rounds; only the subkey changes.
  assign round_sk = (state_reg == ST_RND1) ? (ENCRYPT ? k1_reg : k2_reg)
                                           : (ENCRYPT ? k2_reg : k1_reg);

  sdes_fk u_fk (
    .l     (data_reg[7:4]),
    .r     (data_reg[3:0]),
    .sk    (round_sk),
    .l_out (fk_l),
    .r_out (fk_r)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (in_valid) state_next = ST_KEYGEN;
      ST_KEYGEN: state_next = ST_RND1;
      ST_RND1:   state_next = ST_RND2;
      ST_RND2:   state_next = ST_DONE;
      ST_DONE:   if (out_ready) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_reg == ST_IDLE);
    out_valid = (state_reg == ST_DONE);
    busy      = (state_reg != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_reg       <= '0;
      k1_reg        <= '0;
      k2_reg        <= '0;
      data_reg      <= '0;
      plaintext_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            key_reg  <= key;
            data_reg <= ip(ciphertext);
          end
        end
        ST_KEYGEN: begin
          k1_reg <= k1_next;
          k2_reg <= k2_next;
        end
        // Halves are swapped here so round two sees {R', L'}.
        ST_RND1: data_reg      <= {fk_r, fk_l};
        ST_RND2: plaintext_reg <= ip_inv({fk_l, fk_r});
        default: ;
      endcase
    end
  end

  assign plaintext = plaintext_reg;

endmodule
